// File: rtl/key_pkg.sv
// Shared types and helpers for the single-button BCD value editor.
package key_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EDIT = 1'b1
    } edit_state_t;

    typedef logic [3:0] bcd_t;

    function automatic int ms_to_cycles(input int ms, input int hz);
        return ms * (hz / 1000);
    endfunction

    // One BCD digit step; anything at or above 9 folds back to 0.
    function automatic bcd_t bcd_inc(input bcd_t d);
        bcd_t r;
        if (d >= 4'd9) begin
            r = 4'd0;
        end else begin
            r = d + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ms_timer.sv
// Restartable terminal-count timer: done pulses in the cycle the count sits at
// TERM-1 while enabled, and the count returns to zero on that same edge.
module ms_timer #(
    parameter int TERM = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int W = (TERM > 1) ? $clog2(TERM) : 1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Terminal detect; a clear in the same cycle suppresses the pulse.
    always_comb begin
        done = en && !clr && (cnt_q == W'(TERM - 1));
    end

    // Next count: clear wins, then wrap at terminal, otherwise count while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (done) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/key_edit_ctrl.sv
// Single-button BCD editor: long press enters/advances/commits, short press
// increments the selected digit, inactivity aborts the edit.
module key_edit_ctrl
    import key_pkg::*;
#(
    parameter int                  IN_C_HZ    = 50_000_000,
    parameter int                  DIGITS     = 4,
    parameter int                  BLINK_MS   = 250,
    parameter int                  TIMEOUT_MS = 10_000,
    parameter logic [4*DIGITS-1:0] INIT_VALUE = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_short,
    input  logic                key_long,
    output logic [4*DIGITS-1:0] value_bcd,
    output logic [4*DIGITS-1:0] disp_bcd,
    output logic [DIGITS-1:0]   digit_blank,
    output logic                edit_active,
    output logic                commit,
    output logic                abort
);

    localparam int SEL_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BLINK_CYC   = ms_to_cycles(BLINK_MS, IN_C_HZ);
    localparam int TIMEOUT_CYC = ms_to_cycles(TIMEOUT_MS, IN_C_HZ);

    edit_state_t         state_q,  state_d;
    logic [4*DIGITS-1:0] value_q,  value_d;
    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [SEL_W-1:0]    sel_q,    sel_d;
    logic                phase_q,  phase_d;
    logic                commit_q, commit_d;
    logic                abort_q,  abort_d;
    logic [4*DIGITS-1:0] disp_q,   disp_d;
    logic [DIGITS-1:0]   blank_q,  blank_d;
    logic                edit_q,   edit_d;

    logic key_any_s;
    logic tmr_clr_s;
    logic tmr_en_s;
    logic blink_done_s;
    logic to_done_s;

    // Both timers sit cleared in IDLE and restart on any key pulse while editing.
    always_comb begin
        key_any_s = key_short | key_long;
        tmr_clr_s = (state_q == IDLE) | key_any_s;
        tmr_en_s  = (state_q == EDIT);
    end

    ms_timer #(.TERM(BLINK_CYC)) u_blink_tmr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr_s),
        .en    (tmr_en_s),
        .done  (blink_done_s)
    );

    ms_timer #(.TERM(TIMEOUT_CYC)) u_timeout_tmr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr_s),
        .en    (tmr_en_s),
        .done  (to_done_s)
    );

    // Edit FSM: key_long beats key_short, and any key beats the timeout.
    always_comb begin
        state_d  = state_q;
        value_d  = value_q;
        shadow_d = shadow_q;
        sel_d    = sel_q;
        phase_d  = phase_q;
        commit_d = 1'b0;
        abort_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_long) begin
                    state_d  = EDIT;
                    shadow_d = value_q;
                    sel_d    = '0;
                    phase_d  = 1'b1;
                end else begin
                    state_d  = IDLE;
                end
            end
            EDIT: begin
                if (key_long) begin
                    phase_d = 1'b1;
                    if (sel_q == SEL_W'(DIGITS - 1)) begin
                        value_d  = shadow_q;
                        commit_d = 1'b1;
                        state_d  = IDLE;
                        sel_d    = '0;
                    end else begin
                        sel_d = sel_q + 1'b1;
                    end
                end else if (key_short) begin
                    phase_d = 1'b1;
                    for (int i = 0; i < DIGITS; i++) begin
                        if (SEL_W'(i) == sel_q) begin
                            shadow_d[i*4 +: 4] = bcd_inc(shadow_q[i*4 +: 4]);
                        end else begin
                            shadow_d[i*4 +: 4] = shadow_q[i*4 +: 4];
                        end
                    end
                end else if (to_done_s) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                    sel_d   = '0;
                    phase_d = 1'b1;
                end else if (blink_done_s) begin
                    phase_d = ~phase_q;
                end else begin
                    phase_d = phase_q;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
                phase_d = 1'b1;
            end
        endcase
    end

    // Display-side outputs are computed from next state so they register in step.
    always_comb begin
        edit_d = (state_d == EDIT);
        if (edit_d) begin
            disp_d = shadow_d;
        end else begin
            disp_d = value_d;
        end
        for (int i = 0; i < DIGITS; i++) begin
            blank_d[i] = edit_d && (SEL_W'(i) == sel_d) && !phase_d;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            value_q  <= INIT_VALUE;
            shadow_q <= INIT_VALUE;
            sel_q    <= '0;
            phase_q  <= 1'b1;
            commit_q <= 1'b0;
            abort_q  <= 1'b0;
            disp_q   <= INIT_VALUE;
            blank_q  <= '0;
            edit_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            value_q  <= value_d;
            shadow_q <= shadow_d;
            sel_q    <= sel_d;
            phase_q  <= phase_d;
            commit_q <= commit_d;
            abort_q  <= abort_d;
            disp_q   <= disp_d;
            blank_q  <= blank_d;
            edit_q   <= edit_d;
        end
    end

    assign value_bcd   = value_q;
    assign disp_bcd    = disp_q;
    assign digit_blank = blank_q;
    assign edit_active = edit_q;
    assign commit      = commit_q;
    assign abort       = abort_q;

endmodule

// File: tb/tb_key_edit_ctrl.sv
// Bench for key_edit_ctrl: directed scenarios plus random key traffic, all
// compared each cycle against a digit-array reference model.
module tb_key_edit_ctrl;

    localparam int          IN_C_HZ    = 1000;
    localparam int          DIGITS     = 4;
    localparam int          BLINK_MS   = 4;
    localparam int          TIMEOUT_MS = 20;
    localparam logic [15:0] INIT       = 16'h1234;
    localparam int          B_CYC      = BLINK_MS * (IN_C_HZ / 1000);
    localparam int          T_CYC      = TIMEOUT_MS * (IN_C_HZ / 1000);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_short = 1'b0;
    logic        key_long = 1'b0;
    logic [15:0] value_bcd;
    logic [15:0] disp_bcd;
    logic [3:0]  digit_blank;
    logic        edit_active;
    logic        commit;
    logic        abort;

    key_edit_ctrl #(
        .IN_C_HZ    (IN_C_HZ),
        .DIGITS     (DIGITS),
        .BLINK_MS   (BLINK_MS),
        .TIMEOUT_MS (TIMEOUT_MS),
        .INIT_VALUE (INIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_short   (key_short),
        .key_long    (key_long),
        .value_bcd   (value_bcd),
        .disp_bcd    (disp_bcd),
        .digit_blank (digit_blank),
        .edit_active (edit_active),
        .commit      (commit),
        .abort       (abort)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_commit = 0;
    int n_abort  = 0;

    // Reference model: digits as integers, k = edges since the last key pulse.
    int m_val[DIGITS];
    int m_shd[DIGITS];
    int m_sel;
    int m_k;
    bit m_edit;
    bit m_commit;
    bit m_abort;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] pack(input int arr[DIGITS]);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < DIGITS; i++) p[i*4 +: 4] = 4'(arr[i]);
        return p;
    endfunction

    task automatic model_reset();
        logic [15:0] iv;
        iv = INIT;
        for (int i = 0; i < DIGITS; i++) begin
            m_val[i] = int'(iv[i*4 +: 4]);
            m_shd[i] = m_val[i];
        end
        m_sel = 0; m_k = 0; m_edit = 0; m_commit = 0; m_abort = 0;
    endtask

    task automatic model_edge(input bit s, input bit l);
        m_commit = 0;
        m_abort  = 0;
        if (!m_edit) begin
            if (l) begin
                m_edit = 1; m_shd = m_val; m_sel = 0; m_k = 0;
            end
        end else if (l) begin
            m_k = 0;
            if (m_sel == DIGITS - 1) begin
                m_val = m_shd; m_commit = 1; m_edit = 0; m_sel = 0;
            end else begin
                m_sel++;
            end
        end else if (s) begin
            m_shd[m_sel] = (m_shd[m_sel] + 1) % 10;
            m_k = 0;
        end else begin
            m_k++;
            if (m_k == T_CYC) begin
                m_edit = 0; m_abort = 1; m_sel = 0;
            end
        end
    endtask

    task automatic compare_all();
        logic [3:0] exp_blank;
        exp_blank = '0;
        if (m_edit && (((m_k / B_CYC) % 2) == 1)) exp_blank[m_sel] = 1'b1;
        check_eq("value_bcd",   32'(value_bcd),   32'(pack(m_val)));
        check_eq("disp_bcd",    32'(disp_bcd),    32'(m_edit ? pack(m_shd) : pack(m_val)));
        check_eq("digit_blank", 32'(digit_blank), 32'(exp_blank));
        check_eq("edit_active", 32'(edit_active), 32'(m_edit));
        check_eq("commit",      32'(commit),      32'(m_commit));
        check_eq("abort",       32'(abort),       32'(m_abort));
        if (commit) n_commit++;
        if (abort)  n_abort++;
    endtask

    // One clock: drive at negedge, model the posedge, compare at the next negedge.
    task automatic step(input bit s, input bit l);
        key_short = s;
        key_long  = l;
        @(posedge clk);
        model_edge(s, l);
        @(negedge clk);
        key_short = 1'b0;
        key_long  = 1'b0;
        compare_all();
    endtask

    task automatic do_reset(input bit s, input bit l);
        rst_n     = 1'b0;
        key_short = s;
        key_long  = l;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst_n     = 1'b1;
        key_short = 1'b0;
        key_long  = 1'b0;
        compare_all();
    endtask

    initial begin
        int c0;
        int a0;
        int r;
        model_reset();
        @(negedge clk);
        do_reset(1'b0, 1'b0);
        do_reset(1'b0, 1'b1);
        check_eq("rst_value", 32'(value_bcd), 32'(16'h1234));
        check_eq("rst_blank", 32'(digit_blank), 32'(4'h0));

        // Full edit: long, 3x short, 4x long.
        c0 = n_commit;
        step(1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b0);
        repeat (4) begin
            step(1'b0, 1'b0);
            step(1'b0, 1'b1);
        end
        check_eq("full_commits", 32'(n_commit - c0), 32'd1);
        check_eq("full_value", 32'(value_bcd), 32'(16'h1237));
        check_eq("full_idle", 32'(edit_active), 32'd0);

        // Timeout abort from a fresh reset.
        do_reset(1'b0, 1'b0);
        a0 = n_abort;
        c0 = n_commit;
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        repeat (T_CYC) step(1'b0, 1'b0);
        check_eq("to_aborts", 32'(n_abort - a0), 32'd1);
        check_eq("to_commits", 32'(n_commit - c0), 32'd0);
        check_eq("to_value", 32'(value_bcd), 32'(16'h1234));
        check_eq("to_disp", 32'(disp_bcd), 32'(16'h1234));

        // Wrap: commit digit0 = 9, then edit and increment it to 0.
        step(1'b0, 1'b1);
        repeat (5) step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b1);
        check_eq("pre_wrap_value", 32'(value_bcd), 32'(16'h1239));
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        check_eq("wrap_d0", 32'(disp_bcd[3:0]), 32'd0);
        check_eq("wrap_d1", 32'(disp_bcd[7:4]), 32'd3);

        // Simultaneous pulses at sel=0: advance only, then short hits digit1.
        step(1'b1, 1'b1);
        check_eq("simul_d0", 32'(disp_bcd[3:0]), 32'd0);
        step(1'b1, 1'b0);
        check_eq("simul_low", 32'(disp_bcd[7:0]), 32'(8'h40));

        // Blink on digit1, then reset mid-edit.
        repeat (B_CYC) step(1'b0, 1'b0);
        check_eq("blink_dark", 32'(digit_blank), 32'(4'b0010));
        repeat (B_CYC) step(1'b0, 1'b0);
        check_eq("blink_lit", 32'(digit_blank), 32'(4'b0000));
        step(1'b0, 1'b0);
        c0 = n_commit;
        a0 = n_abort;
        do_reset(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check_eq("mid_rst_value", 32'(value_bcd), 32'(16'h1234));
        check_eq("mid_rst_edit", 32'(edit_active), 32'd0);
        check_eq("mid_rst_pulses", 32'((n_commit - c0) + (n_abort - a0)), 32'd0);

        // Random key traffic with occasional long idle gaps and resets.
        for (int it = 0; it < 3000; it++) begin
            r = $urandom_range(0, 99);
            if (r == 0) begin
                do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else if (r < 3) begin
                repeat (T_CYC + 2) step(1'b0, 1'b0);
            end else if (r < 13) begin
                step(1'b0, 1'b1);
            end else if (r < 16) begin
                step(1'b1, 1'b1);
            end else if (r < 45) begin
                step(1'b1, 1'b0);
            end else begin
                step(1'b0, 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
